umi_decode_pipe: RTL and testbench
==================================

Name: umi_decode_pipe

Overview:
- Registered, flow-controlled successor to the combinational UMI command decoder.
- Accepts a valid/ready UMI command stream of parametrised command and payload width, and classifies each opcode {command[6:0], write} into one of 17 classes.
- Presents the packet with a binary and one-hot class tag after one cycle through a 2-entry skid buffer.
- Keeps per-class saturating transaction counters and a sticky unknown-opcode flag for debug and status.

Parameters:
- CW, 7: command width; must be >= 7. Bits [CW-1:7] are reserved.
- DW, 64: payload width, passed through untouched.
- CNTW, 16: per-class statistics counter width.

Ports:
- clk  input  1  clock.
- nreset  input  1  asynchronous active-low reset.
- umi_in_valid  input  1  input packet valid.
- umi_in_cmd  input  CW  input command.
- umi_in_write  input  1  input write bit.
- umi_in_data  input  DW  input payload.
- umi_in_ready  output  1  input accept.
- umi_out_valid  output  1  output packet valid.
- umi_out_cmd  output  CW  registered command.
- umi_out_write  output  1  registered write bit.
- umi_out_data  output  DW  registered payload.
- umi_out_class  output  5  binary class index, 0..16.
- umi_out_onehot  output  17  one-hot class; bit n corresponds to class n.
- umi_out_atomic  output  1  opcode[3:0] equals the ATOMIC group code.
- umi_out_ready  input  1  downstream accept.
- stat_clear  input  1  synchronous clear of all counters and the error flag.
- stat_sel  input  5  counter select.
- stat_count  output  CNTW  selected counter value (combinational mux of registers).
- err_unknown  output  1  sticky flag: an UNKNOWN packet was delivered.

Behaviour:
- Class map, using the umi_messages.vh encodings:
  - 0 INVALID, 1 READ_REQUEST, 2 WRITE_POSTED, 3 WRITE_SIGNAL, 4 WRITE_ACK, 5 WRITE_STREAM, 6 WRITE_RESPONSE.
  - 7 ATOMIC_SWAP, 8 ADD, 9 AND, 10 OR, 11 XOR, 12 MIN, 13 MAX, 14 MINU, 15 MAXU.
  - 16 UNKNOWN: any other opcode, or any nonzero reserved bit umi_in_cmd[CW-1:7].
- Decode is computed on input and stored with the packet; the output tag is never re-decoded. umi_out_onehot is exactly one-hot whenever umi_out_valid=1.
- Reset (nreset low, asynchronous):
  - umi_out_valid=0, umi_in_ready=1.
  - All counters 0, err_unknown=0, buffer empty.
  - Data/cmd/class registers 0; umi_out_onehot bit 0 = 1.
  - Deassertion is synchronised externally.
- Buffer: main output register plus one skid entry, occupancy 0..2.
  - umi_in_ready is registered: 1 iff the skid entry is empty. It is never combinationally dependent on umi_out_ready.
  - Input handshake: umi_in_valid & umi_in_ready. Output handshake: umi_out_valid & umi_out_ready.
  - Latency: a packet accepted at edge N is on the outputs after edge N when the output stage is empty or draining.
  - Output stage holds while umi_out_valid=1 & umi_out_ready=0; all output fields stay stable.
  - If the output is stalled and an input is accepted, the input goes to skid and umi_in_ready drops the next cycle.
  - Simultaneous input and output handshake at occupancy 1: the output register loads the new packet; occupancy stays 1.
  - At occupancy 2 an output handshake moves skid into output; umi_in_ready rises the next cycle.
  - Full throughput: one packet per cycle with umi_out_ready held high.
  - Strict order is preserved; no packet is dropped or duplicated.
- Counters:
  - counter[umi_out_class] increments on each output handshake, saturating at 2^CNTW-1 (no wrap).
  - stat_clear=1 zeroes all counters at the edge and takes priority over a same-cycle increment; the result is 0.
  - stat_sel>16 returns 0.
- err_unknown: set on an output handshake of class 16; cleared by stat_clear. A same-cycle set beats clear, so the error is never lost.
- umi_in_valid while umi_in_ready=0 is ignored; the upstream must hold the packet.

Test Plan:
- Reset mid-stream: 2 packets buffered with out_ready=0, pulse nreset -> out_valid=0, in_ready=1, all counters 0, err_unknown=0 immediately; the old packets never appear.
- Streaming: 16 packets, one per class 0..15, with out_ready=1 -> back-to-back output with 1-cycle latency, correct class/onehot for each, counters 0..15 each read 1, err_unknown=0.
- Backpressure: out_ready=0 with 3 packets offered -> 2 accepted, in_ready=0 from the cycle after the 2nd accept. Raise out_ready -> order A, B, then C; no loss.
- Reserved bits: CW=8 with cmd[7]=1 on a READ_REQUEST opcode -> class 16, onehot bit 16, err_unknown=1 after the handshake, counter[1] unchanged.
- Saturation: CNTW=4, 20 WRITE_POSTED packets -> counter[2]=15. stat_clear in the same cycle as a WRITE_POSTED handshake -> counter[2]=0.
- Clear vs error: stat_clear coincident with an UNKNOWN handshake -> err_unknown=1 and counter[16]=0 after the edge.

Source files
------------

// File: rtl/umi_decode_pipe.sv
// Registered UMI command classifier: 1-cycle latency through a main register plus one skid entry.
// umi_in_ready is a flop that drops only when the skid entry fills, so it never depends on umi_out_ready.
module umi_decode_pipe #(
   parameter int CW   = 7,
   parameter int DW   = 64,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            umi_in_valid,
   input  logic [CW-1:0]   umi_in_cmd,
   input  logic            umi_in_write,
   input  logic [DW-1:0]   umi_in_data,
   output logic            umi_in_ready,
   output logic            umi_out_valid,
   output logic [CW-1:0]   umi_out_cmd,
   output logic            umi_out_write,
   output logic [DW-1:0]   umi_out_data,
   output logic [4:0]      umi_out_class,
   output logic [16:0]     umi_out_onehot,
   output logic            umi_out_atomic,
   input  logic            umi_out_ready,
   input  logic            stat_clear,
   input  logic [4:0]      stat_sel,
   output logic [CNTW-1:0] stat_count,
   output logic            err_unknown
);

   localparam int NCLS = 17;

   typedef struct packed {
      logic [CW-1:0]   cmd;
      logic            write;
      logic [DW-1:0]   data;
      logic [4:0]      cls;
      logic [NCLS-1:0] onehot;
      logic            atomic;
   } ent_t;

   localparam ent_t RST_ENT = '{cmd: '0, write: 1'b0, data: '0, cls: 5'd0,
                                onehot: NCLS'(1), atomic: 1'b0};

   logic       rsv_nz;
   logic [7:0] opcode;
   logic [4:0] in_cls;
   logic [NCLS-1:0] in_onehot;
   ent_t       in_ent;

   if (CW > 7) begin : g_rsv
      assign rsv_nz = |umi_in_cmd[CW-1:7];
   end else begin : g_no_rsv
      assign rsv_nz = 1'b0;
   end

   assign opcode = {umi_in_cmd[6:0], umi_in_write};

   always_comb begin
      in_cls = 5'd16;
      case (opcode)
         8'h00: in_cls = 5'd0;   // INVALID
         8'h02: in_cls = 5'd1;   // READ_REQUEST
         8'h01: in_cls = 5'd2;   // WRITE_POSTED
         8'h03: in_cls = 5'd3;   // WRITE_SIGNAL
         8'h09: in_cls = 5'd4;   // WRITE_ACK
         8'h07: in_cls = 5'd5;   // WRITE_STREAM
         8'h05: in_cls = 5'd6;   // WRITE_RESPONSE
         8'h88: in_cls = 5'd7;   // ATOMIC_SWAP
         8'h08: in_cls = 5'd8;   // ATOMIC_ADD
         8'h18: in_cls = 5'd9;   // ATOMIC_AND
         8'h28: in_cls = 5'd10;  // ATOMIC_OR
         8'h38: in_cls = 5'd11;  // ATOMIC_XOR
         8'h58: in_cls = 5'd12;  // ATOMIC_MIN
         8'h48: in_cls = 5'd13;  // ATOMIC_MAX
         8'h78: in_cls = 5'd14;  // ATOMIC_MINU
         8'h68: in_cls = 5'd15;  // ATOMIC_MAXU
         default: in_cls = 5'd16;
      endcase
      if (rsv_nz) in_cls = 5'd16;
   end

   always_comb begin
      in_onehot = '0;
      for (int i = 0; i < NCLS; i++) in_onehot[i] = (in_cls == 5'(i));
   end

   always_comb begin
      in_ent        = RST_ENT;
      in_ent.cmd    = umi_in_cmd;
      in_ent.write  = umi_in_write;
      in_ent.data   = umi_in_data;
      in_ent.cls    = in_cls;
      in_ent.onehot = in_onehot;
      in_ent.atomic = (opcode[3:0] == 4'h8);
   end

   ent_t out_q, skid_q;
   logic out_vld, skid_vld, in_rdy;
   logic in_hs, out_hs;

   assign in_hs  = umi_in_valid & in_rdy;
   assign out_hs = out_vld & umi_out_ready;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         out_q    <= RST_ENT;
         skid_q   <= RST_ENT;
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         in_rdy   <= 1'b1;
      end else if (!out_vld || out_hs) begin
         // Output stage free this cycle: skid has priority to keep order.
         if (skid_vld) begin
            out_q    <= skid_q;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
            in_rdy   <= 1'b1;
         end else if (in_hs) begin
            out_q   <= in_ent;
            out_vld <= 1'b1;
         end else begin
            out_vld <= 1'b0;
         end
      end else if (in_hs) begin
         skid_q   <= in_ent;
         skid_vld <= 1'b1;
         in_rdy   <= 1'b0;
      end
   end

   assign umi_in_ready   = in_rdy;
   assign umi_out_valid  = out_vld;
   assign umi_out_cmd    = out_q.cmd;
   assign umi_out_write  = out_q.write;
   assign umi_out_data   = out_q.data;
   assign umi_out_class  = out_q.cls;
   assign umi_out_onehot = out_q.onehot;
   assign umi_out_atomic = out_q.atomic;

   logic [CNTW-1:0] cnt [NCLS];
   logic            err_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < NCLS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCLS; i++) begin
            if (stat_clear)
               cnt[i] <= '0;
            else if (out_hs && out_q.cls == 5'(i) && cnt[i] != {CNTW{1'b1}})
               cnt[i] <= cnt[i] + CNTW'(1);
         end
      end
   end

   // Set wins over clear so an error coinciding with a clear is not lost.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
         err_q <= 1'b0;
      else if (out_hs && out_q.cls == 5'd16)
         err_q <= 1'b1;
      else if (stat_clear)
         err_q <= 1'b0;
   end

   assign err_unknown = err_q;

   always_comb begin
      stat_count = '0;
      for (int i = 0; i < NCLS; i++)
         if (stat_sel == 5'(i)) stat_count = cnt[i];
   end

endmodule

// File: tb/tb_umi_decode_pipe.sv
// Directed bench for umi_decode_pipe (CW=8, CNTW=4) with immediate assertions at every check.
module tb_umi_decode_pipe;

   localparam int CW   = 8;
   localparam int DW   = 64;
   localparam int CNTW = 4;

   logic            clk = 1'b0;
   logic            nreset = 1'b1;
   logic            umi_in_valid = 1'b0;
   logic [CW-1:0]   umi_in_cmd = '0;
   logic            umi_in_write = 1'b0;
   logic [DW-1:0]   umi_in_data = '0;
   logic            umi_in_ready;
   logic            umi_out_valid;
   logic [CW-1:0]   umi_out_cmd;
   logic            umi_out_write;
   logic [DW-1:0]   umi_out_data;
   logic [4:0]      umi_out_class;
   logic [16:0]     umi_out_onehot;
   logic            umi_out_atomic;
   logic            umi_out_ready = 1'b0;
   logic            stat_clear = 1'b0;
   logic [4:0]      stat_sel = '0;
   logic [CNTW-1:0] stat_count;
   logic            err_unknown;

   int n_checks = 0;
   int n_fails  = 0;

   // Hand-written opcode {cmd[6:0], write} for classes 0..15.
   logic [7:0] ops [16] = '{8'h00, 8'h02, 8'h01, 8'h03, 8'h09, 8'h07, 8'h05, 8'h88,
                            8'h08, 8'h18, 8'h28, 8'h38, 8'h58, 8'h48, 8'h78, 8'h68};

   umi_decode_pipe #(.CW(CW), .DW(DW), .CNTW(CNTW)) dut (
      .clk(clk), .nreset(nreset),
      .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd), .umi_in_write(umi_in_write),
      .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
      .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd), .umi_out_write(umi_out_write),
      .umi_out_data(umi_out_data), .umi_out_class(umi_out_class), .umi_out_onehot(umi_out_onehot),
      .umi_out_atomic(umi_out_atomic), .umi_out_ready(umi_out_ready),
      .stat_clear(stat_clear), .stat_sel(stat_sel), .stat_count(stat_count),
      .err_unknown(err_unknown)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [7:0] op, input logic [63:0] data);
      umi_in_valid = vld;
      umi_in_cmd   = {1'b0, op[7:1]};
      umi_in_write = op[0];
      umi_in_data  = data;
   endtask

   task automatic chk_cnt(input string tag, input logic [4:0] sel, input logic [63:0] exp);
      stat_sel = sel;
      #1;
      chk(tag, 64'(stat_count), exp);
   endtask

   initial begin
      // Reset state
      #2 nreset = 1'b0;
      #1;
      chk("rst_out_valid", 64'(umi_out_valid), 64'd0);
      chk("rst_in_ready", 64'(umi_in_ready), 64'd1);
      chk("rst_class", 64'(umi_out_class), 64'd0);
      chk("rst_onehot", 64'(umi_out_onehot), 64'h1);
      chk("rst_data", umi_out_data, 64'd0);
      chk("rst_err", 64'(err_unknown), 64'd0);
      chk_cnt("rst_cnt0", 5'd0, 64'd0);
      #10 nreset = 1'b1;
      tick();

      // Streaming classes 0..15 back to back
      umi_out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, ops[i], 64'hA000 + 64'(i));
         tick();
         chk("str_valid", 64'(umi_out_valid), 64'd1);
         chk("str_class", 64'(umi_out_class), 64'(i));
         chk("str_onehot", 64'(umi_out_onehot), 64'd1 << i);
         chk("str_data", umi_out_data, 64'hA000 + 64'(i));
         chk("str_cmd", 64'(umi_out_cmd), 64'(ops[i][7:1]));
         chk("str_write", 64'(umi_out_write), 64'(ops[i][0]));
         chk("str_atomic", 64'(umi_out_atomic), (i >= 7) ? 64'd1 : 64'd0);
         chk("str_in_ready", 64'(umi_in_ready), 64'd1);
      end
      drive(1'b0, 8'h00, 64'd0);
      tick();
      chk("str_drained", 64'(umi_out_valid), 64'd0);
      for (int s = 0; s < 16; s++) chk_cnt("str_cnt", 5'(s), 64'd1);
      chk_cnt("str_cnt16", 5'd16, 64'd0);
      chk_cnt("sel_oob", 5'd20, 64'd0);
      chk("str_err", 64'(err_unknown), 64'd0);

      // Backpressure: A, B accepted, C held off
      umi_out_ready = 1'b0;
      drive(1'b1, 8'h01, 64'hAAAA);
      tick();
      chk("bp_a_out", umi_out_data, 64'hAAAA);
      chk("bp_a_rdy", 64'(umi_in_ready), 64'd1);
      drive(1'b1, 8'h02, 64'hBBBB);
      tick();
      chk("bp_b_rdy", 64'(umi_in_ready), 64'd0);
      chk("bp_b_hold", umi_out_data, 64'hAAAA);
      drive(1'b1, 8'h08, 64'hCCCC);
      tick();
      chk("bp_c_rdy", 64'(umi_in_ready), 64'd0);
      chk("bp_c_hold", umi_out_data, 64'hAAAA);
      chk("bp_c_hold_cls", 64'(umi_out_class), 64'd2);
      umi_out_ready = 1'b1;
      tick();
      chk("bp_out_b", umi_out_data, 64'hBBBB);
      chk("bp_out_b_cls", 64'(umi_out_class), 64'd1);
      chk("bp_rdy_back", 64'(umi_in_ready), 64'd1);
      tick();
      chk("bp_out_c", umi_out_data, 64'hCCCC);
      chk("bp_out_c_atomic", 64'(umi_out_atomic), 64'd1);
      chk("bp_out_c_valid", 64'(umi_out_valid), 64'd1);
      drive(1'b0, 8'h00, 64'd0);
      tick();
      chk("bp_drained", 64'(umi_out_valid), 64'd0);
      chk_cnt("bp_cnt1", 5'd1, 64'd2);
      chk_cnt("bp_cnt8", 5'd8, 64'd2);

      // Reserved bit set on a READ_REQUEST opcode
      umi_in_valid = 1'b1;
      umi_in_cmd   = 8'h81;
      umi_in_write = 1'b0;
      umi_in_data  = 64'h5151;
      tick();
      chk("rsv_class", 64'(umi_out_class), 64'd16);
      chk("rsv_onehot", 64'(umi_out_onehot), 64'h10000);
      chk("rsv_err_before", 64'(err_unknown), 64'd0);
      drive(1'b0, 8'h00, 64'd0);
      tick();
      chk("rsv_err_after", 64'(err_unknown), 64'd1);
      chk_cnt("rsv_cnt1", 5'd1, 64'd2);
      chk_cnt("rsv_cnt16", 5'd16, 64'd1);

      // Reset mid-stream with two packets buffered
      umi_out_ready = 1'b0;
      drive(1'b1, 8'h09, 64'hD1);
      tick();
      drive(1'b1, 8'h09, 64'hD2);
      tick();
      chk("mid_full", 64'(umi_in_ready), 64'd0);
      drive(1'b0, 8'h00, 64'd0);
      nreset = 1'b0;
      #1;
      chk("mid_out_valid", 64'(umi_out_valid), 64'd0);
      chk("mid_in_ready", 64'(umi_in_ready), 64'd1);
      chk("mid_err", 64'(err_unknown), 64'd0);
      chk_cnt("mid_cnt1", 5'd1, 64'd0);
      chk_cnt("mid_cnt16", 5'd16, 64'd0);
      chk_cnt("mid_cnt4", 5'd4, 64'd0);
      #7 nreset = 1'b1;
      umi_out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mid_no_ghost", 64'(umi_out_valid), 64'd0);
      end

      // Saturation of counter[2]
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 8'h01, 64'(k));
         tick();
         if (k == 15) chk_cnt("sat_mid", 5'd2, 64'd15);
      end
      drive(1'b0, 8'h00, 64'd0);
      tick();
      chk_cnt("sat_cnt2", 5'd2, 64'd15);

      // Clear coincident with a WRITE_POSTED handshake
      drive(1'b1, 8'h01, 64'hE0);
      tick();
      drive(1'b0, 8'h00, 64'd0);
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      chk_cnt("clr_cnt2", 5'd2, 64'd0);
      chk("clr_drained", 64'(umi_out_valid), 64'd0);

      // Clear coincident with an UNKNOWN handshake
      drive(1'b1, 8'hFF, 64'hF0);
      tick();
      chk("unk_class", 64'(umi_out_class), 64'd16);
      drive(1'b0, 8'h00, 64'd0);
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      chk("unk_err_kept", 64'(err_unknown), 64'd1);
      chk_cnt("unk_cnt16", 5'd16, 64'd0);
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      chk("unk_err_cleared", 64'(err_unknown), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
